pad_input_filter: RTL and testbench

PAD_INPUT_FILTER -- requirements
Module: pad_input_filter

---
 rtl/pad_input_filter.sv | 65 ++++++
 tb/tb_pad_input_filter.sv | 108 ++++++++++
 2 files changed

// File: rtl/pad_input_filter.sv
// pad_input_filter: synchronizes a raw pad input, debounces it, and produces edge pulses and a sticky interrupt.
module pad_input_filter #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pad_in_i,
  input  logic       en_i,
  input  logic       filter_en_i,
  input  logic [1:0] irq_mode_i,
  input  logic       irq_clr_i,
  output logic       level_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       irq_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE_CYCLES);
  // Bit 1 of the encoding is the filtered level; the CHECK states have differing bits.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHECK_HI  = 2'b01,
    STABLE_HI = 2'b11,
    CHECK_LO  = 2'b10
  } state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0] cnt, n;
  logic filter_en_q, sync_q, diff, done, check;
  assign sync_q  = sync_r[SYNC_STAGES-1];
  assign level_o = state[1];
  assign check   = state[1] ^ state[0];
  assign diff    = sync_q != level_o;
  assign n       = filter_en_i ? DB : CW'(1);
  assign done    = ({1'b0, cnt} + (CW+1)'(1)) >= {1'b0, n};
  always_ff @(posedge clk_i) begin
    sync_r      <= rst_i ? {SYNC_STAGES{RESET_VAL}} : {sync_r[SYNC_STAGES-2:0], pad_in_i};
    filter_en_q <= filter_en_i;
    if (rst_i) begin
      state  <= RESET_VAL ? STABLE_HI : STABLE_LO;
      cnt    <= '0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      irq_o  <= (rise_o & irq_mode_i[0]) | (fall_o & irq_mode_i[1]) | (irq_o & ~irq_clr_i);
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      cnt    <= '0;
      // A change of filter mode mid-qualification restarts it under the new length.
      if (!en_i || !diff || (check && filter_en_i != filter_en_q)) begin
        state <= level_o ? STABLE_HI : STABLE_LO;
      end else if (done) begin
        state  <= sync_q ? STABLE_HI : STABLE_LO;
        rise_o <= sync_q;
        fall_o <= ~sync_q;
      end else begin
        state <= sync_q ? CHECK_HI : CHECK_LO;
        cnt   <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_pad_input_filter.sv
// tb_pad_input_filter: directed and random stimulus scored against a cycle-level behavioural model.
module tb_pad_input_filter;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam bit RV = 1'b0;
  logic clk = 0, rst, pad, en, fe, clr;
  logic [1:0] mode;
  logic level, rise, fall, irq;
  int vectors = 0, errors = 0, cyc = 0;
  logic [3:0] exp_q[$];
  pad_input_filter #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .RESET_VAL(RV)) dut (
    .clk_i(clk), .rst_i(rst), .pad_in_i(pad), .en_i(en), .filter_en_i(fe),
    .irq_mode_i(mode), .irq_clr_i(clr), .level_o(level), .rise_o(rise),
    .fall_o(fall), .irq_o(irq)
  );
  always #5 clk = ~clk;
  // Model: pad history shift line, count of consecutive differing edges, and output registers.
  bit [7:0] hist;
  int run;
  bit m_lvl, m_rise, m_fall, m_irq, m_fe_prev;
  task automatic step(input bit r, p, e, f, input bit [1:0] md, input bit c);
    int nlen = f ? DB : 1;
    bit sq = hist[SS-1];
    bit nl = m_lvl, nr = 0, nf = 0, ni;
    if (r) begin
      hist = RV ? '1 : '0;
      m_lvl = RV; run = 0; m_rise = 0; m_fall = 0; m_irq = 0;
    end else begin
      ni = ((m_rise && md[0]) || (m_fall && md[1])) ? 1'b1 : (c ? 1'b0 : m_irq);
      if (e && sq != m_lvl) begin
        if (f != m_fe_prev && run > 0) run = 0;
        else begin
          run++;
          if (run >= nlen) begin nl = sq; nr = sq; nf = !sq; run = 0; end
        end
      end else run = 0;
      hist = {hist[6:0], p};
      m_lvl = nl; m_rise = nr; m_fall = nf; m_irq = ni;
    end
    m_fe_prev = f;
  endtask
  task automatic drive(input bit r, p, e, f, input bit [1:0] md, input bit c);
    @(negedge clk);
    rst = r; pad = p; en = e; fe = f; mode = md; clr = c;
    step(r, p, e, f, md, c);
    exp_q.push_back({m_lvl, m_rise, m_fall, m_irq});
  endtask
  always @(posedge clk) begin
    cyc++;
    #1;
    if (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      vectors++;
      if ({level, rise, fall, irq} !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: level/rise/fall/irq got %b expected %b", cyc, {level, rise, fall, irq}, e);
      end
    end
  end
  initial begin
    bit p = 0, f = 1;
    bit [1:0] md = 2'b11;
    int hold = 0;
    rst = 1; pad = 0; en = 1; fe = 1; mode = 0; clr = 0;
    // Pad high through reset release: rise after the 6th edge.
    repeat (2) drive(1, 1, 1, 1, 2'b00, 0);
    repeat (8) drive(0, 1, 1, 1, 2'b00, 0);
    repeat (10) drive(0, 0, 1, 1, 2'b00, 0);
    // Short glitch rejected by the debounce.
    repeat (3) drive(0, 1, 1, 1, 2'b00, 0);
    repeat (8) drive(0, 0, 1, 1, 2'b00, 0);
    // Bypass: two-cycle pulse passes through.
    repeat (2) drive(0, 1, 1, 0, 2'b00, 0);
    repeat (6) drive(0, 0, 1, 0, 2'b00, 0);
    // Both-edge interrupt; clear coincident with the fall pulse loses to the set.
    repeat (6) drive(0, 1, 1, 0, 2'b11, 0);
    repeat (3) drive(0, 0, 1, 0, 2'b11, 0);
    drive(0, 0, 1, 0, 2'b11, 1);
    repeat (3) drive(0, 0, 1, 0, 2'b11, 0);
    drive(0, 0, 1, 0, 2'b11, 1);
    repeat (3) drive(0, 0, 1, 0, 2'b11, 0);
    // Reset during qualification with the counter at 3.
    repeat (5) drive(0, 1, 1, 1, 2'b00, 0);
    drive(1, 1, 1, 1, 2'b00, 0);
    repeat (8) drive(0, 0, 1, 1, 2'b00, 0);
    // Disabled block ignores the pad, then qualifies once enabled.
    repeat (6) drive(0, 1, 0, 1, 2'b00, 0);
    repeat (6) drive(0, 1, 1, 1, 2'b00, 0);
    repeat (10) drive(0, 0, 1, 1, 2'b00, 0);
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin p = $urandom_range(1, 0); hold = $urandom_range(8, 1); end
      hold--;
      if ($urandom_range(19, 0) == 0) f = !f;
      if ($urandom_range(19, 0) == 0) md = 2'($urandom_range(3, 0));
      drive($urandom_range(99, 0) == 0, p, $urandom_range(9, 0) != 0, f, md,
            $urandom_range(9, 0) == 0);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never observed, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
